// File: rtl/alu_pkg.sv
// Shared encodings, SR bit positions and widths for the ALU status unit.
package alu_pkg;

  localparam int DATA_W = 20;
  localparam int HALF_W = 10;
  localparam int SR_W   = 8;

  typedef enum logic [2:0] {
    FLOW_NOP  = 3'd0,
    FLOW_JMP  = 3'd1,
    FLOW_JZ   = 3'd2,
    FLOW_JS   = 3'd3,
    FLOW_JZS  = 3'd4,
    FLOW_LSR  = 3'd5,
    FLOW_XSR  = 3'd6,
    FLOW_TRAP = 3'd7
  } flow_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  localparam int SR_Z = 0;
  localparam int SR_S = 1;
  localparam int SR_C = 2;
  localparam int SR_M = 3;
  localparam int SR_T = 4;

  localparam logic [SR_W-1:0] LSR_MASK = 8'h1F;
  localparam logic [SR_W-1:0] XSR_MASK = 8'h0F;

endpackage

// File: rtl/alu_branch_cond.sv
// Branch condition evaluator: decides whether a flow op redirects fetch.
// Purely combinational; evaluated against the SR value before the update edge.
module alu_branch_cond
  import alu_pkg::*;
(
  input  logic [2:0]      flow_op,
  input  logic [SR_W-1:0] sr,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (flow_op_e'(flow_op))
      FLOW_JMP: taken = 1'b1;
      FLOW_JZ:  taken = sr[SR_Z];
      FLOW_JS:  taken = sr[SR_S];
      FLOW_JZS: taken = sr[SR_Z] | sr[SR_S];
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_status_unit.sv
// ALU status unit: SR maintenance, flow-op resolution, registered writeback; 1-cycle latency.
// Stalls intake while writeback is held by wb_ready=0 or while halted in TRAP.
module alu_status_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_zero,
  input  logic              res_sign,
  input  logic              res_carry,
  input  logic              res_mode,
  input  logic [2:0]        res_fmask,
  input  logic [2:0]        flow_op,
  input  logic [DATA_W-1:0] flow_target,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic              br_valid,
  output logic [DATA_W-1:0] br_target,
  output logic [SR_W-1:0]   sr,
  output logic              trap_active,
  input  logic              trap_clear
);

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              br_valid_q, br_valid_d;
  logic [DATA_W-1:0] br_target_q, br_target_d;
  logic              taken;
  logic              xfer;

  alu_branch_cond u_branch_cond (
    .flow_op (flow_op),
    .sr      (sr_q),
    .taken   (taken)
  );

  // rst_n gates ready so nothing is advertised while reset is held
  assign res_ready = rst_n && (state_q == ST_RUN) && (!wb_valid_q || wb_ready);
  assign xfer      = res_valid && res_ready;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    wb_valid_d  = wb_valid_q && !wb_ready;
    wb_data_d   = wb_data_q;
    br_valid_d  = 1'b0;
    br_target_d = br_target_q;

    if (xfer) begin
      case (flow_op_e'(flow_op))
        FLOW_NOP: begin
          wb_valid_d = 1'b1;
          wb_data_d  = res_mode ? res_data
                                : {{(DATA_W-HALF_W){1'b0}}, res_data[HALF_W-1:0]};
          if (res_fmask[0]) sr_d[SR_Z] = res_zero;
          if (res_fmask[1]) sr_d[SR_S] = res_sign;
          if (res_fmask[2]) sr_d[SR_C] = res_carry;
          sr_d[SR_M] = res_mode;
        end
        FLOW_JMP, FLOW_JZ, FLOW_JS, FLOW_JZS: begin
          if (taken) begin
            br_valid_d  = 1'b1;
            br_target_d = flow_target;
          end
        end
        FLOW_LSR: begin
          sr_d       = res_data[SR_W-1:0] & LSR_MASK;
          sr_d[SR_T] = sr_q[SR_T];
        end
        FLOW_XSR: sr_d = sr_q ^ (res_data[SR_W-1:0] & XSR_MASK);
        FLOW_TRAP: begin
          sr_d[SR_T] = 1'b1;
          state_d    = ST_TRAP;
        end
        default: ;
      endcase
    end

    if (state_q == ST_TRAP && trap_clear) begin
      sr_d[SR_T] = 1'b0;
      state_d    = ST_RUN;
    end

    sr_d[SR_W-1:SR_T+1] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      sr_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      br_valid_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      br_valid_q  <= br_valid_d;
      br_target_q <= br_target_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign br_valid    = br_valid_q;
  assign br_target   = br_target_q;
  assign sr          = sr_q;
  assign trap_active = (state_q == ST_TRAP);

endmodule

// File: tb/tb_alu_status_unit.sv
// Directed bench for alu_status_unit with hand-computed expectations.
module tb_alu_status_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [19:0] res_data;
  logic        res_zero, res_sign, res_carry, res_mode;
  logic [2:0]  res_fmask;
  logic [2:0]  flow_op;
  logic [19:0] flow_target;
  logic        wb_valid, wb_ready;
  logic [19:0] wb_data;
  logic        br_valid;
  logic [19:0] br_target;
  logic [7:0]  sr;
  logic        trap_active, trap_clear;

  int n_pass  = 0;
  int n_total = 0;

  alu_status_unit dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_sign(res_sign), .res_carry(res_carry),
    .res_mode(res_mode), .res_fmask(res_fmask),
    .flow_op(flow_op), .flow_target(flow_target),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .br_valid(br_valid), .br_target(br_target), .sr(sr),
    .trap_active(trap_active), .trap_clear(trap_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, take one edge, then drop valid.
  task automatic send(input logic [2:0] op, input logic [19:0] data, input logic mode,
                      input logic [2:0] fmask, input logic z, input logic s, input logic c,
                      input logic [19:0] tgt);
    flow_op = op; res_data = data; res_mode = mode; res_fmask = fmask;
    res_zero = z; res_sign = s; res_carry = c; flow_target = tgt;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; res_valid = 1'b0; res_data = '0; res_zero = 1'b0; res_sign = 1'b0;
    res_carry = 1'b0; res_mode = 1'b0; res_fmask = '0; flow_op = '0; flow_target = '0;
    wb_ready = 1'b1; trap_clear = 1'b0;
    #2;
    chk("rst_ready", res_ready, 0);
    chk("rst_sr", sr, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", res_ready, 1);
    chk("post_rst_wbv", wb_valid, 0);
    chk("post_rst_brv", br_valid, 0);
    chk("post_rst_trap", trap_active, 0);

    // Half-word data op with all flags enabled
    send(3'd0, 20'hABCDE, 1'b0, 3'b111, 1'b0, 1'b1, 1'b1, 20'h0);
    chk("d1_wbv", wb_valid, 1);
    chk("d1_wbd", wb_data, 20'h000DE);
    chk("d1_sr", sr, 8'h06);
    tick();
    chk("d1_drain", wb_valid, 0);

    // Full-word op clearing Z/S/C, M=1
    send(3'd0, 20'h12345, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 20'h0);
    chk("d2_wbd", wb_data, 20'h12345);
    chk("d2_sr", sr, 8'h08);

    // Z-only update then JZ on the very next cycle
    send(3'd0, 20'h00000, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 20'h0);
    chk("d3_sr", sr, 8'h09);
    send(3'd2, 20'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 20'h00400);
    chk("jz_brv", br_valid, 1);
    chk("jz_tgt", br_target, 20'h00400);
    chk("jz_no_wb", wb_valid, 0);
    chk("jz_sr", sr, 8'h09);
    tick();
    chk("jz_pulse_end", br_valid, 0);
    send(3'd3, 20'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 20'h00800);
    chk("js_not_taken", br_valid, 0);
    chk("js_tgt_hold", br_target, 20'h00400);
    send(3'd4, 20'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 20'h00123);
    chk("jzs_brv", br_valid, 1);
    chk("jzs_tgt", br_target, 20'h00123);

    // LSR / XSR
    send(3'd5, 20'h000FF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 20'h0);
    chk("lsr_sr", sr, 8'h0F);
    send(3'd6, 20'h00005, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 20'h0);
    chk("xsr_sr", sr, 8'h0A);
    send(3'd3, 20'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 20'h00777);
    chk("js_after_xsr", br_valid, 1);
    chk("js_after_xsr_tgt", br_target, 20'h00777);
    send(3'd1, 20'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 20'h00ABC);
    chk("jmp_brv", br_valid, 1);
    chk("jmp_tgt", br_target, 20'h00ABC);

    // Writeback stall
    wb_ready = 1'b0;
    send(3'd0, 20'h11111, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 20'h0);
    chk("st_wbd1", wb_data, 20'h11111);
    flow_op = 3'd0; res_data = 20'h22222; res_mode = 1'b1; res_fmask = 3'b000;
    res_valid = 1'b1;
    #1;
    chk("st_ready_low", res_ready, 0);
    tick();
    chk("st_hold_wbd", wb_data, 20'h11111);
    chk("st_hold_wbv", wb_valid, 1);
    wb_ready = 1'b1;
    #1;
    chk("st_ready_high", res_ready, 1);
    tick();
    res_valid = 1'b0;
    chk("st_wbd2", wb_data, 20'h22222);
    chk("st_wbv2", wb_valid, 1);
    chk("st_sr", sr, 8'h0A);
    tick();
    chk("st_drain", wb_valid, 0);

    // Trap and release
    send(3'd7, 20'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 20'h0);
    chk("trap_active", trap_active, 1);
    chk("trap_sr", sr, 8'h1A);
    flow_op = 3'd0; res_data = 20'h33333; res_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("trap_ready_low", res_ready, 0);
      tick();
    end
    res_valid = 1'b0;
    chk("trap_no_wb", wb_valid, 0);
    chk("trap_wbd_hold", wb_data, 20'h22222);
    trap_clear = 1'b1;
    #1;
    chk("clr_same_cycle", res_ready, 0);
    tick();
    trap_clear = 1'b0;
    chk("clr_trap", trap_active, 0);
    chk("clr_sr", sr, 8'h0A);
    chk("clr_ready", res_ready, 1);
    trap_clear = 1'b1;
    tick();
    trap_clear = 1'b0;
    chk("clr_run_sr", sr, 8'h0A);
    chk("clr_run_trap", trap_active, 0);

    // Async reset while writeback is stalled
    wb_ready = 1'b0;
    send(3'd0, 20'h44444, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 20'h0);
    chk("ar1_wbv", wb_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar1_wbv0", wb_valid, 0);
    chk("ar1_wbd0", wb_data, 0);
    chk("ar1_tgt0", br_target, 0);
    chk("ar1_sr0", sr, 0);
    tick();
    rst_n = 1'b1;
    wb_ready = 1'b1;

    // Async reset while halted in TRAP
    send(3'd1, 20'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 20'h00555);
    send(3'd0, 20'h66666, 1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 20'h0);
    send(3'd7, 20'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 20'h0);
    chk("ar2_trap", trap_active, 1);
    chk("ar2_sr", sr, 8'h1F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar2_trap0", trap_active, 0);
    chk("ar2_sr0", sr, 0);
    chk("ar2_wbd0", wb_data, 0);
    chk("ar2_tgt0", br_target, 0);
    chk("ar2_ready0", res_ready, 0);
    chk("ar2_brv0", br_valid, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("ar2_run_ready", res_ready, 1);
    send(3'd0, 20'h789AB, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 20'h0);
    chk("ar2_wbd", wb_data, 20'h001AB);
    chk("ar2_sr_after", sr, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
